// File: rtl/testez_monitor.sv
// -----------------------------------------------------------------------------
// testez_monitor
//
// Monitors the three outputs (o, p, q) of the upstream decode stage. Each
// input passes through two register ranks. The monitor detects rising edges
// and keeps a saturating edge count for each signal. Every cycle that has at
// least one rise queues one event ({rise mask, timestamp}) in a small
// first-word-fall-through FIFO, which a host drains with rd. A hold detector
// raises alarm when the registered o stays high for HOLD consecutive samples.
//
// Ports
//   clk       in   single clock; all state changes on its rising edge
//   rst       in   asynchronous active-low reset, released synchronously
//   o, p, q   in   decode-stage outputs being monitored
//   clr       in   synchronous clear of counters, ovf and hold detector
//   rd        in   pop request for the event FIFO (ignored while empty)
//   ev_valid  out  event FIFO not empty
//   ev_data   out  head entry {mask[2:0] = {o,p,q rise}, ts[TS_W-1:0]}, 0 when empty
//   o_cnt     out  saturating rising-edge count of o
//   p_cnt     out  saturating rising-edge count of p
//   q_cnt     out  saturating rising-edge count of q
//   ovf       out  sticky: an event was dropped because the FIFO was full
//   alarm     out  o has been held high for HOLD samples
// -----------------------------------------------------------------------------
module testez_monitor #(
  parameter int CNT_W = 8,
  parameter int TS_W  = 8,
  parameter int DEPTH = 4,
  parameter int HOLD  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              o,
  input  logic              p,
  input  logic              q,
  input  logic              clr,
  input  logic              rd,
  output logic              ev_valid,
  output logic [TS_W+2:0]   ev_data,
  output logic [CNT_W-1:0]  o_cnt,
  output logic [CNT_W-1:0]  p_cnt,
  output logic [CNT_W-1:0]  q_cnt,
  output logic              ovf,
  output logic              alarm
);

  localparam int AW    = $clog2(DEPTH);
  localparam int DW    = TS_W + 3;
  localparam int RUN_W = 8;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [RUN_W-1:0] HOLD_V  = RUN_W'(HOLD);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COUNT,
    ST_ALARM
  } hold_state_t;

  // ---------------------------------------------------------------------------
  // Input stage. Bit 2 is o, bit 1 is p, bit 0 is q, which matches the mask
  // layout in ev_data.
  // ---------------------------------------------------------------------------
  logic [2:0] r_in_r;
  logic [2:0] r_in_rr;
  logic [2:0] w_mask;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples the values from before the edge, whatever order the
  // blocks are evaluated in.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_in_r  <= '0;
      r_in_rr <= '0;
    end else begin
      r_in_r  <= {o, p, q};
      r_in_rr <= r_in_r;
    end
  end

  // Both ranks reset to 0, so an input that is already high when reset is
  // released still produces exactly one rise.
  assign w_mask = r_in_r & ~r_in_rr;

  // ---------------------------------------------------------------------------
  // Saturating edge counters. clr wins over a rise in the same cycle.
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] r_cnt [3];

  for (genvar g = 0; g < 3; g++) begin : g_cnt
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_cnt[g] <= '0;
      end else if (clr) begin
        r_cnt[g] <= '0;
      end else if (w_mask[g] && (r_cnt[g] != CNT_MAX)) begin
        r_cnt[g] <= r_cnt[g] + 1'b1;
      end
    end
  end

  assign o_cnt = r_cnt[2];
  assign p_cnt = r_cnt[1];
  assign q_cnt = r_cnt[0];

  // ---------------------------------------------------------------------------
  // Free-running timestamp. It wraps naturally and clr does not touch it.
  // ---------------------------------------------------------------------------
  logic [TS_W-1:0] r_ts;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ts <= '0;
    end else begin
      r_ts <= r_ts + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Event FIFO. The pointers carry one extra wrap bit so that full and empty
  // can be told apart without a separate occupancy counter.
  // ---------------------------------------------------------------------------
  logic [DW-1:0] r_mem [DEPTH];
  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;
  logic          r_ovf;

  logic w_empty;
  logic w_full;
  logic w_push;
  logic w_pop;
  logic w_wr_en;
  logic w_drop;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

  assign w_push  = |w_mask;
  // A pop needs a valid head. This also makes rd a no-op on an empty FIFO
  // when a push arrives in the same cycle.
  assign w_pop   = rd && !w_empty;
  // A full FIFO can still accept a push when a pop frees a slot in the same
  // cycle.
  assign w_wr_en = w_push && (!w_full || w_pop);
  assign w_drop  = w_push && w_full && !w_pop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

  // NOTE: the storage array has no reset. The pointers define which entries
  // are live, and ev_data is forced to 0 while the FIFO is empty, so stale
  // contents are never visible.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr[AW-1:0]] <= {w_mask, r_ts};
    end
  end

  // The ovf flag is sticky. clr takes priority over a drop in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ovf <= 1'b0;
    end else if (clr) begin
      r_ovf <= 1'b0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
    end
  end

  assign ev_valid = !w_empty;
  assign ev_data  = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
  assign ovf      = r_ovf;

  // ---------------------------------------------------------------------------
  // Hold detector on o_r. r_run counts consecutive high samples and
  // saturates at HOLD. The alarm output is the registered ALARM state.
  // ---------------------------------------------------------------------------
  hold_state_t      r_state;
  logic [RUN_W-1:0] r_run;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_run   <= '0;
    end else if (clr) begin
      r_state <= ST_IDLE;
      r_run   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (r_in_r[2]) begin
            r_run   <= RUN_W'(1);
            r_state <= (HOLD_V == RUN_W'(1)) ? ST_ALARM : ST_COUNT;
          end
        end
        ST_COUNT: begin
          if (r_in_r[2]) begin
            r_run <= r_run + RUN_W'(1);
            if ((r_run + RUN_W'(1)) == HOLD_V) begin
              r_state <= ST_ALARM;
            end
          end else begin
            r_run   <= '0;
            r_state <= ST_IDLE;
          end
        end
        ST_ALARM: begin
          if (!r_in_r[2]) begin
            r_run   <= '0;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_run   <= '0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign alarm = (r_state == ST_ALARM);

endmodule

// File: tb/tb_testez_monitor.sv
// -----------------------------------------------------------------------------
// tb_testez_monitor
//
// Directed bench for testez_monitor with CNT_W=3, TS_W=8, DEPTH=4, HOLD=4.
// Inputs change 1 time unit after each rising edge, and outputs are sampled
// at that same point. Expected timestamps come from a cycle counter that
// the bench keeps itself.
// -----------------------------------------------------------------------------
module tb_testez_monitor;

  localparam int CNT_W = 3;
  localparam int TS_W  = 8;
  localparam int DEPTH = 4;
  localparam int HOLD  = 4;

  logic             clk;
  logic             rst;
  logic             o;
  logic             p;
  logic             q;
  logic             clr;
  logic             rd;
  logic             ev_valid;
  logic [TS_W+2:0]  ev_data;
  logic [CNT_W-1:0] o_cnt;
  logic [CNT_W-1:0] p_cnt;
  logic [CNT_W-1:0] q_cnt;
  logic             ovf;
  logic             alarm;

  int             checks;
  int             errors;
  logic [TS_W-1:0] ts_m;
  logic [TS_W-1:0] exp_ts [6];
  logic [TS_W-1:0] e0;
  int             drain_idx [4];

  testez_monitor #(
    .CNT_W (CNT_W),
    .TS_W  (TS_W),
    .DEPTH (DEPTH),
    .HOLD  (HOLD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .o        (o),
    .p        (p),
    .q        (q),
    .clr      (clr),
    .rd       (rd),
    .ev_valid (ev_valid),
    .ev_data  (ev_data),
    .o_cnt    (o_cnt),
    .p_cnt    (p_cnt),
    .q_cnt    (q_cnt),
    .ovf      (ovf),
    .alarm    (alarm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Advance one rising edge and land 1 time unit after it. ts_m tracks the
  // DUT timestamp, which increments on every edge taken out of reset.
  task automatic step();
    @(posedge clk);
    #1;
    if (rst) ts_m = ts_m + 1'b1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ev_valid"}, 32'(ev_valid), 32'd0);
    check({tag, "_ev_data"},  32'(ev_data),  32'd0);
    check({tag, "_o_cnt"},    32'(o_cnt),    32'd0);
    check({tag, "_p_cnt"},    32'(p_cnt),    32'd0);
    check({tag, "_q_cnt"},    32'(q_cnt),    32'd0);
    check({tag, "_ovf"},      32'(ovf),      32'd0);
    check({tag, "_alarm"},    32'(alarm),    32'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    ts_m   = '0;
    rst = 1'b0; o = 1'b0; p = 1'b0; q = 1'b0; clr = 1'b0; rd = 1'b0;

    // Reset held with the inputs toggling.
    repeat (4) begin
      step();
      o = 1'($urandom); p = 1'($urandom); q = 1'($urandom); rd = 1'($urandom);
    end
    check_all_zero("rst_hold");
    o = 1'b0; p = 1'b0; q = 1'b0; rd = 1'b0;
    step();
    rst = 1'b1;

    // Idle after release.
    repeat (10) step();
    check_all_zero("idle");

    // A single p pulse gives 2-cycle latency and mask 010.
    e0 = ts_m + 1'b1;
    p = 1'b1;
    step();
    p = 1'b0;
    check("p_latency_cnt",   32'(p_cnt),    32'd0);
    check("p_latency_valid", 32'(ev_valid), 32'd0);
    step();
    check("p_cnt_1",     32'(p_cnt),    32'd1);
    check("p_ev_valid",  32'(ev_valid), 32'd1);
    check("p_ev_data",   32'(ev_data),  32'({3'b010, e0}));
    rd = 1'b1;
    step();
    rd = 1'b0;
    check("p_pop_valid", 32'(ev_valid), 32'd0);
    check("p_pop_data",  32'(ev_data),  32'd0);

    // A push into an empty FIFO with rd high keeps the push and ignores rd.
    e0 = ts_m + 1'b1;
    p = 1'b1;
    step();
    p = 1'b0;
    rd = 1'b1;
    step();
    rd = 1'b0;
    check("emptyrd_valid", 32'(ev_valid), 32'd1);
    check("emptyrd_data",  32'(ev_data),  32'({3'b010, e0}));
    check("emptyrd_p_cnt", 32'(p_cnt),    32'd2);
    rd = 1'b1;
    step();
    rd = 1'b0;
    check("emptyrd_drain", 32'(ev_valid), 32'd0);

    // Overflow: five q rises with no rd. Four are kept and the fifth is dropped.
    for (int k = 0; k < 5; k++) begin
      exp_ts[k] = ts_m + 1'b1;
      q = 1'b1;
      step();
      q = 1'b0;
      step();
    end
    check("ovf_q_cnt", 32'(q_cnt),    32'd5);
    check("ovf_flag",  32'(ovf),      32'd1);
    check("ovf_valid", 32'(ev_valid), 32'd1);
    check("ovf_head",  32'(ev_data),  32'({3'b001, exp_ts[0]}));

    // Full FIFO with a push and a pop in the same cycle loses nothing.
    exp_ts[5] = ts_m + 1'b1;
    q = 1'b1;
    step();
    q = 1'b0;
    rd = 1'b1;
    step();
    rd = 1'b0;
    check("fullpp_q_cnt", 32'(q_cnt), 32'd6);
    drain_idx[0] = 1; drain_idx[1] = 2; drain_idx[2] = 3; drain_idx[3] = 5;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("drain_%0d", k), 32'(ev_data), 32'({3'b001, exp_ts[drain_idx[k]]}));
      rd = 1'b1;
      step();
      rd = 1'b0;
    end
    check("drain_empty", 32'(ev_valid), 32'd0);

    // Saturation: nine o rises saturate a 3-bit counter at 7.
    repeat (9) begin
      o = 1'b1;
      step();
      o = 1'b0;
      step();
    end
    check("sat_o_cnt", 32'(o_cnt), 32'd7);
    check("sat_ovf",   32'(ovf),   32'd1);
    check("sat_alarm", 32'(alarm), 32'd0);

    // clr in the same cycle as an o rise (which the full FIFO drops).
    o = 1'b1;
    step();
    o = 1'b0;
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("clr_o_cnt", 32'(o_cnt),    32'd0);
    check("clr_p_cnt", 32'(p_cnt),    32'd0);
    check("clr_q_cnt", 32'(q_cnt),    32'd0);
    check("clr_ovf",   32'(ovf),      32'd0);
    check("clr_fifo",  32'(ev_valid), 32'd1);
    rd = 1'b1;
    repeat (4) step();
    rd = 1'b0;
    check("clr_drain", 32'(ev_valid), 32'd0);

    // Hold: o is high for 6 cycles. alarm rises after the 5th edge and
    // falls 2 edges after o drops.
    o = 1'b1;
    repeat (4) step();
    check("hold_early", 32'(alarm), 32'd0);
    step();
    check("hold_on", 32'(alarm), 32'd1);
    step();
    o = 1'b0;
    step();
    check("hold_stay", 32'(alarm), 32'd1);
    step();
    check("hold_off", 32'(alarm), 32'd0);

    // o is high for only 3 cycles, so alarm never asserts.
    o = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("short_hi_%0d", k), 32'(alarm), 32'd0);
    end
    o = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("short_lo_%0d", k), 32'(alarm), 32'd0);
    end

    // Asynchronous reset with 3 entries queued and alarm high.
    o = 1'b1;
    repeat (6) step();
    check("pre_rst_alarm", 32'(alarm),    32'd1);
    check("pre_rst_valid", 32'(ev_valid), 32'd1);
    check("pre_rst_o_cnt", 32'(o_cnt),    32'd3);
    #2;
    rst = 1'b0;
    o   = 1'b0;
    #1;
    check_all_zero("async_rst");
    ts_m = '0;
    step();
    step();
    rst = 1'b1;
    repeat (3) step();
    check_all_zero("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/testez_monitor.md
# testez_monitor

Sequential monitor that sits directly downstream of the `o`/`p`/`q` combinational decode stage and consumes its three outputs. It registers the signals, detects rising edges, and keeps a saturating edge count per signal. Each edge event is queued with a timestamp in a small first-word-fall-through FIFO for a host reader. A hold detector raises `alarm` when `o` stays high for too long.

## Interface

Parameters:
- `CNT_W`, 8, width of each edge counter.
- `TS_W`, 8, width of the free-running timestamp.
- `DEPTH`, 4, event FIFO depth; must be a power of two, ≥2.
- `HOLD`, 4, number of consecutive high samples of `o` that raises `alarm`; range 1..255.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-low reset: `rst`=0 resets immediately; release is synchronous to `clk`.
- `o`, `p`, `q`  in  1 each  outputs of the upstream decode stage.
- `clr`  in  1  synchronous clear of counters, `ovf` and the hold detector; the FIFO is not affected.
- `rd`  in  1  pop request for the event FIFO.
- `ev_valid`  out  1  FIFO not empty.
- `ev_data`  out  3+TS_W  head entry `{mask[2:0]={o,p,q rise}, ts[TS_W-1:0]}`.
- `o_cnt`, `p_cnt`, `q_cnt`  out  CNT_W each  rising-edge counts.
- `ovf`  out  1  sticky flag: an event was dropped.
- `alarm`  out  1  `o` hold violation.

## Operation

- **Input stage:** two register ranks per signal, `x_r` then `x_rr`. Rise is `x_r & ~x_rr`.
- **Reset of input registers:** both ranks reset to 0. An input already high when reset is released therefore produces one rise.
- **Counters:**
  - +1 per rise; saturate at 2^CNT_W−1 with no wrap.
  - `clr` has priority over a simultaneous rise: the counter becomes 0.
- **Timestamp:**
  - `ts` is a TS_W counter, +1 every cycle out of reset.
  - Wraps from 2^TS_W−1 to 0.
  - `clr` does not affect it.
- **Event push:**
  - A push occurs in any cycle where the mask is nonzero.
  - The entry stores the mask and the current `ts` value, i.e. the value before that edge's increment.
  - Simultaneous rises share one entry with multiple mask bits set.
- **FIFO:**
  - `ev_valid` = !empty; `ev_data` = head entry, combinationally from storage.
  - A pop happens when `rd` & `ev_valid`; `rd` while empty is ignored.
  - Full & push & pop: both happen, no loss.
  - Full & push & no pop: the entry is dropped and `ovf` is set until `clr` or reset.
  - Empty & push & `rd`: the push is accepted and `rd` is ignored.
  - `ev_data` is 0 when the FIFO is empty.
- **Hold detector** (run counter 0..HOLD, saturating), evaluated on `o_r`:
  - IDLE (run=0): if `o_r`=1 → COUNT with run=1, or directly to ALARM when HOLD=1.
  - COUNT: `o_r`=1 → run+1, entering ALARM when run reaches HOLD; `o_r`=0 → IDLE.
  - ALARM: stays while `o_r`=1; `o_r`=0 → IDLE.
  - `alarm` = (state==ALARM).
  - `clr` forces IDLE.
- **Reset values:** all counters 0, `ts`=0, FIFO empty, `ev_valid`=0, `ev_data`=0, `ovf`=0, `alarm`=0, state IDLE.
- **Reset mid-operation:** all state is lost immediately, including queued events.

## Timing

- An input rise sampled at edge t (`x_r`=1 after t) is counted and pushed at edge t+1.
  - Counter and `ev_valid` are visible after t+1, i.e. 2-cycle latency.
- A pop at edge t makes the next entry visible after t.
- Back-to-back pops sustain 1 entry per cycle.
- `alarm` asserts after the edge at which `o_r` has been 1 for HOLD consecutive edges.
  - It deasserts one edge after `o_r` falls, which is 2 cycles after `o` falls.
- `clr` takes effect at the edge where it is sampled high.
- No combinational path from `o`/`p`/`q` to any output.
- `rd` affects only state, not outputs, in the same cycle.

## Test plan

- **Reset/idle:** hold `rst`=0 with inputs toggling → all outputs 0. Release with inputs low, run 10 cycles → outputs stay 0, `ts`=10.
- **Single edge:** pulse `p` 0→1 one cycle at cycle 5 → `p_cnt`=1 two edges later; `ev_valid`=1; `ev_data` mask=3'b010 with `ts`= push-cycle value. `rd` one cycle → `ev_valid`=0.
- **Overflow:** with DEPTH=4 and no `rd`, generate 5 separate `q` rises → 4 entries kept, 5th dropped, `ovf`=1, `q_cnt`=5. Then one `rd` with a simultaneous rise → no new overflow, still 4 entries.
- **Saturation and clr:** CNT_W=3, 9 rises on `o` → `o_cnt`=7. Pulse `clr` in the same cycle as a rise → `o_cnt`=0, `ovf`=0.
- **Hold:** HOLD=4, hold `o`=1 for 6 cycles → `alarm` rises after the 4th `o_r` sample and falls 2 cycles after `o` drops. With `o` high for only 3 cycles → `alarm` never asserts.
- **Async reset mid-run:** assert `rst`=0 between clock edges with 3 FIFO entries queued and `alarm`=1 → all outputs 0 immediately, without waiting for a clock edge.
